// File: rtl/ryuki_datatypes_pkg.sv
// ryuki_datatypes: shared trace record type plus the serialiser's word-count
// constants and word-index enum.
//
// Build option: TRACE_MEM_ACCESS_EN
//   defined   -> if_data carries mem_access; 8 words per record
//   undefined -> no mem_access field at all; 6 words per record
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package ryuki_datatypes;

  typedef struct packed {
    logic signed [`DATA_WIDTH-1:0] time_start;
    logic signed [`DATA_WIDTH-1:0] time_end;
  } mem_access_t;

  typedef struct packed {
`ifdef TRACE_MEM_ACCESS_EN
    mem_access_t                   mem_access;
`endif
    logic signed [`DATA_WIDTH-1:0] time_start;
    logic signed [`DATA_WIDTH-1:0] time_end;
  } if_data_t;

  typedef struct packed {
    logic signed [`DATA_WIDTH-1:0] time_start;
    logic signed [`DATA_WIDTH-1:0] time_end;
  } id_data_t;

  typedef struct packed {
    logic [`DATA_WIDTH-1:0] instruction;
    logic [`ADDR_WIDTH-1:0] addr;
    if_data_t               if_data;
    id_data_t               id_data;
  } trace_output;

`ifdef TRACE_MEM_ACCESS_EN
  localparam int unsigned TRACE_WORDS = 8;
  typedef enum logic [2:0] {
    WI_INSTR     = 3'd0,
    WI_ADDR      = 3'd1,
    WI_IF_START  = 3'd2,
    WI_IF_END    = 3'd3,
    WI_MEM_START = 3'd4,
    WI_MEM_END   = 3'd5,
    WI_ID_START  = 3'd6,
    WI_ID_END    = 3'd7
  } word_idx_e;
`else
  localparam int unsigned TRACE_WORDS = 6;
  typedef enum logic [2:0] {
    WI_INSTR     = 3'd0,
    WI_ADDR      = 3'd1,
    WI_IF_START  = 3'd2,
    WI_IF_END    = 3'd3,
    WI_ID_START  = 3'd4,
    WI_ID_END    = 3'd5
  } word_idx_e;
`endif

  localparam word_idx_e WI_LAST = word_idx_e'(TRACE_WORDS - 1);

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: FIFO of trace_output records.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_data   write a record (ignored when full)
//   pop               drop the head record (ignored when empty)
//   head              current head record (undefined when empty)
//   full, empty       occupancy flags
//   single            exactly one entry held
module trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  trace_output push_data,
  input  logic        pop,
  output trace_output head,
  output logic        full,
  output logic        empty,
  output logic        single
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  trace_output      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign single  = (count == (PTR_W+1)'(1));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; it is only observed through the head
  // once a push has filled the slot.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/trace_serialiser.sv
// trace_serialiser: buffers trace records and emits each one as a sequence
// of WORD_WIDTH words over a valid/ready stream.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   trace_valid_i/trace_i/ready_o  record input handshake
//   word_valid_o/data_o/last_o     word output, last marks final word
//   word_ready_i                   downstream accept
//   records_sent_o                 fully transmitted record count (wraps)
// Build option: TRACE_MEM_ACCESS_EN adds the two mem_access words.
//
// state | meaning
// IDLE  | FIFO empty, no word offered
// SEND  | serialising FIFO head at word index idx
module trace_serialiser
  import ryuki_datatypes::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trace_valid_i,
  input  trace_output           trace_i,
  output logic                  trace_ready_o,
  output logic                  word_valid_o,
  output logic [WORD_WIDTH-1:0] word_data_o,
  output logic                  word_last_o,
  input  logic                  word_ready_i,
  output logic [31:0]           records_sent_o
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e      state;
  word_idx_e   idx;
  logic        ready_en;
  logic [31:0] sent;
  trace_output head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_single;
  logic        push;
  logic        word_hs;
  logic        last_hs;

  // ready_en keeps trace_ready_o low through reset and releases it on the
  // first edge afterwards.
  assign trace_ready_o  = ready_en && !fifo_full;
  assign push           = trace_valid_i && trace_ready_o;
  assign word_valid_o   = (state == SEND);
  assign word_last_o    = word_valid_o && (idx == WI_LAST);
  assign word_hs        = word_valid_o && word_ready_i;
  assign last_hs        = word_hs && word_last_o;
  assign records_sent_o = sent;

  trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (trace_i),
    .pop       (last_hs),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .single    (fifo_single)
  );

  // State tracks FIFO occupancy one step ahead so a record pushed into an
  // empty FIFO is offered in the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= WI_INSTR;
      ready_en <= 1'b0;
      sent     <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          idx <= WI_INSTR;
          if (push) state <= SEND;
        end
        SEND: begin
          if (word_hs) begin
            if (idx == WI_LAST) begin
              idx  <= WI_INSTR;
              sent <= sent + 32'd1;
              if (fifo_single && !push) state <= IDLE;
            end else begin
              idx <= word_idx_e'(idx + 3'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    word_data_o = '0;
    if (word_valid_o && !fifo_empty) begin
      case (idx)
        WI_INSTR:     word_data_o = head.instruction;
        WI_ADDR:      word_data_o = head.addr;
        WI_IF_START:  word_data_o = head.if_data.time_start;
        WI_IF_END:    word_data_o = head.if_data.time_end;
`ifdef TRACE_MEM_ACCESS_EN
        WI_MEM_START: word_data_o = head.if_data.mem_access.time_start;
        WI_MEM_END:   word_data_o = head.if_data.mem_access.time_end;
`endif
        WI_ID_START:  word_data_o = head.id_data.time_start;
        WI_ID_END:    word_data_o = head.id_data.time_end;
        default:      word_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_serialiser.sv
`timescale 1ns/1ps
module tb_trace_serialiser;
  import ryuki_datatypes::*;

  localparam int DEPTH = 4;
  localparam trace_output NULL_REC = '0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_valid_i = 1'b0;
  trace_output trace_i = '0;
  logic        trace_ready_o;
  logic        word_valid_o;
  logic [31:0] word_data_o;
  logic        word_last_o;
  logic        word_ready_i = 1'b0;
  logic [31:0] records_sent_o;

  always #5 clk = ~clk;

  trace_serialiser #(.FIFO_DEPTH(DEPTH), .WORD_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trace_valid_i  (trace_valid_i),
    .trace_i        (trace_i),
    .trace_ready_o  (trace_ready_o),
    .word_valid_o   (word_valid_o),
    .word_data_o    (word_data_o),
    .word_last_o    (word_last_o),
    .word_ready_i   (word_ready_i),
    .records_sent_o (records_sent_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: records waiting, position in head record, sent count.
  typedef logic [31:0] word_q_t[$];
  trace_output m_q[$];
  int          m_widx  = 0;
  logic [31:0] m_sent  = '0;
  bit          m_armed = 0;

  function automatic word_q_t words_of(input trace_output r);
    word_q_t q;
    q.push_back(r.instruction);
    q.push_back(r.addr);
    q.push_back(r.if_data.time_start);
    q.push_back(r.if_data.time_end);
`ifdef TRACE_MEM_ACCESS_EN
    q.push_back(r.if_data.mem_access.time_start);
    q.push_back(r.if_data.mem_access.time_end);
`endif
    q.push_back(r.id_data.time_start);
    q.push_back(r.id_data.time_end);
    return q;
  endfunction

  function automatic trace_output mk_rec(input logic [31:0] ins, input logic [31:0] ad,
                                         input logic [31:0] t0, input logic [31:0] t1,
                                         input logic [31:0] t2, input logic [31:0] t3,
                                         input logic [31:0] t4, input logic [31:0] t5);
    trace_output r;
    r = '0;
    r.instruction        = ins;
    r.addr               = ad;
    r.if_data.time_start = t0;
    r.if_data.time_end   = t1;
`ifdef TRACE_MEM_ACCESS_EN
    r.if_data.mem_access.time_start = t2;
    r.if_data.mem_access.time_end   = t3;
`endif
    r.id_data.time_start = t4;
    r.id_data.time_end   = t5;
    return r;
  endfunction

  function automatic trace_output rand_rec();
    return mk_rec($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endfunction

  // Called #1 after an edge: compare outputs to the model, drive inputs,
  // advance one clock, update the model, return #1 after the edge.
  task automatic step(input logic tv, input trace_output rec, input logic wr, output bit pushed);
    word_q_t w;
    bit exp_valid, exp_ready, exp_last;
    exp_valid = (m_q.size() > 0);
    exp_ready = m_armed && (m_q.size() < DEPTH);
    exp_last  = 0;
    check("trace_ready", {31'd0, trace_ready_o}, {31'd0, exp_ready});
    check("word_valid", {31'd0, word_valid_o}, {31'd0, exp_valid});
    check("records_sent", records_sent_o, m_sent);
    if (exp_valid) begin
      w = words_of(m_q[0]);
      exp_last = (m_widx == w.size() - 1);
      check("word_data", word_data_o, w[m_widx]);
      check("word_last", {31'd0, word_last_o}, {31'd0, exp_last});
    end
    trace_valid_i = tv;
    trace_i       = rec;
    word_ready_i  = wr;
    @(posedge clk);
    if (exp_valid && wr) begin
      if (exp_last) begin
        void'(m_q.pop_front());
        m_widx = 0;
        m_sent = m_sent + 32'd1;
      end else begin
        m_widx++;
      end
    end
    pushed = tv && exp_ready;
    if (pushed) m_q.push_back(rec);
    m_armed = 1;
    #1;
  endtask

  task automatic idle(input logic wr);
    bit p;
    step(1'b0, NULL_REC, wr, p);
  endtask

  task automatic offer(input trace_output rec);
    bit p;
    step(1'b1, rec, 1'b0, p);
  endtask

  task automatic reset_and_check(input int lead);
    #(lead);
    rst_n = 1'b0;
    trace_valid_i = 1'b0;
    word_ready_i  = 1'b0;
    #1;
    check("rst_word_valid", {31'd0, word_valid_o}, 32'd0);
    check("rst_word_data", word_data_o, 32'd0);
    check("rst_word_last", {31'd0, word_last_o}, 32'd0);
    check("rst_trace_ready", {31'd0, trace_ready_o}, 32'd0);
    check("rst_records_sent", records_sent_o, 32'd0);
    m_q.delete();
    m_widx  = 0;
    m_sent  = '0;
    m_armed = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        last;
  } tvec_t;

  tvec_t       tbl_a[$];
  tvec_t       tbl_b[$];
  trace_output rec_a, rec_b, rec_c, rec_d, rec_e, rec_f;
  trace_output burst[5];
  word_q_t     wq;
  bit          pushed;
  int          budget;

  task automatic run_table(input tvec_t t[$]);
    for (int i = 0; i < t.size(); i++) begin
      check("tbl_valid", {31'd0, word_valid_o}, 32'd1);
      check("tbl_data", word_data_o, t[i].data);
      check("tbl_last", {31'd0, word_last_o}, {31'd0, t[i].last});
      idle(t[i].wr);
    end
  endtask

  initial begin
    rec_a = mk_rec(32'h13, 32'h80, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
    rec_b = mk_rec(32'h33, 32'h84, 32'hFFFF_FFFF, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11);

    tbl_a.push_back('{1'b1, 32'h13, 1'b0});
    tbl_a.push_back('{1'b1, 32'h80, 1'b0});
    tbl_a.push_back('{1'b1, 32'd1, 1'b0});
    tbl_a.push_back('{1'b1, 32'd2, 1'b0});
`ifdef TRACE_MEM_ACCESS_EN
    tbl_a.push_back('{1'b1, 32'd3, 1'b0});
    tbl_a.push_back('{1'b1, 32'd4, 1'b0});
`endif
    tbl_a.push_back('{1'b1, 32'd5, 1'b0});
    tbl_a.push_back('{1'b1, 32'd6, 1'b1});

    // Stall three cycles on the negative if_data.time_start word.
    tbl_b.push_back('{1'b1, 32'h33, 1'b0});
    tbl_b.push_back('{1'b1, 32'h84, 1'b0});
    tbl_b.push_back('{1'b0, 32'hFFFF_FFFF, 1'b0});
    tbl_b.push_back('{1'b0, 32'hFFFF_FFFF, 1'b0});
    tbl_b.push_back('{1'b0, 32'hFFFF_FFFF, 1'b0});
    tbl_b.push_back('{1'b1, 32'hFFFF_FFFF, 1'b0});
    tbl_b.push_back('{1'b1, 32'd7, 1'b0});
`ifdef TRACE_MEM_ACCESS_EN
    tbl_b.push_back('{1'b1, 32'd8, 1'b0});
    tbl_b.push_back('{1'b1, 32'd9, 1'b0});
`endif
    tbl_b.push_back('{1'b1, 32'd10, 1'b0});
    tbl_b.push_back('{1'b1, 32'd11, 1'b1});

    reset_and_check(1);
    idle(1'b0);

    // Single record, ready held high, then a record with a stalled word.
    offer(rec_a);
    run_table(tbl_a);
    check("sent_after_a", records_sent_o, 32'd1);
    offer(rec_b);
    run_table(tbl_b);
    check("sent_after_b", records_sent_o, 32'd2);
    idle(1'b1);

    // Two queued records: no bubble between them.
    rec_c = rand_rec();
    rec_d = rand_rec();
    offer(rec_c);
    offer(rec_d);
    wq = words_of(rec_c);
    for (int i = 0; i < 2 * wq.size(); i++) begin
      check("b2b_valid", {31'd0, word_valid_o}, 32'd1);
      idle(1'b1);
    end
    check("b2b_drained", {31'd0, word_valid_o}, 32'd0);
    check("b2b_sent", records_sent_o, 32'd4);

    // Five records offered with downstream stalled; fifth waits for a pop.
    for (int k = 0; k < 5; k++) burst[k] = rand_rec();
    for (int k = 0; k < 4; k++) offer(burst[k]);
    check("full_ready_low", {31'd0, trace_ready_o}, 32'd0);
    step(1'b1, burst[4], 1'b0, pushed);
    check("fifth_rejected", {31'd0, pushed}, 32'd0);
    pushed = 0;
    budget = 0;
    while (!pushed && budget < 50) begin
      step(1'b1, burst[4], 1'b1, pushed);
      budget++;
    end
    check("fifth_accepted", {31'd0, pushed}, 32'd1);
    check("fifth_after_first", records_sent_o, 32'd5);
    budget = 0;
    while (m_q.size() > 0 && budget < 100) begin
      idle(1'b1);
      budget++;
    end
    check("burst_drained", m_q.size(), 32'd0);

    // Reset partway through a record.
    rec_e = rand_rec();
    rec_f = rand_rec();
    offer(rec_e);
    for (int i = 0; i < 3; i++) idle(1'b1);
    reset_and_check(2);
    idle(1'b1);
    idle(1'b1);
    offer(rec_f);
    check("restart_instr", word_data_o, rec_f.instruction);
    budget = 0;
    while (m_q.size() > 0 && budget < 50) begin
      idle(1'b1);
      budget++;
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, rand_rec(), $urandom_range(0, 3) != 0, pushed);
    end
    budget = 0;
    while (m_q.size() > 0 && budget < 200) begin
      idle(1'b1);
      budget++;
    end
    check("final_drained", m_q.size(), 32'd0);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trace_serialiser.md
TRACE_SERIALISER -- requirements
Module: trace_serialiser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, record FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter WORD_WIDTH, default 32, output word width (equals `DATA_WIDTH and `ADDR_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port trace_valid_i  input  1  trace record offered.
REQ-006 SHALL have port trace_i  input  trace_output  record: instruction, addr, if_data (incl. mem_access), id_data.
REQ-007 SHALL have port trace_ready_o  output  1  record accepted when valid and ready.
REQ-008 SHALL have port word_valid_o  output  1  output word present.
REQ-009 SHALL have port word_data_o  output  WORD_WIDTH  output word.
REQ-010 SHALL have port word_last_o  output  1  final word of current record.
REQ-011 SHALL have port word_ready_i  input  1  downstream accepts word when valid and ready.
REQ-012 SHALL have port records_sent_o  output  32  count of fully transmitted records.

Function
REQ-013 SHALL store accepted records in a FIFO of FIFO_DEPTH entries; trace_ready_o = FIFO not full.
REQ-014 SHALL permit push and pop in the same cycle when not full; occupancy then unchanged.
REQ-015 SHALL not accept a record when full, even if a pop occurs that cycle.
REQ-016 SHALL present a record accepted at edge N with word_valid_o high from cycle after edge N (1-cycle latency when FIFO empty).
REQ-017 SHALL use states IDLE (FIFO empty, word_valid_o=0) and SEND (word_valid_o=1, serialising FIFO head).
REQ-018 SHALL transition IDLE->SEND when FIFO non-empty; SEND->IDLE on last-word handshake with no further entry (after pop).
REQ-019 SHALL emit words in order: instruction, addr, if_data.time_start, if_data.time_end, [mem_access.time_start, mem_access.time_end], id_data.time_start, id_data.time_end.
REQ-020 SHALL transmit integer fields as their 32-bit two's-complement bit pattern, unmodified.
REQ-021 SHALL hold word_data_o and word_last_o stable while word_valid_o=1 and word_ready_i=0.
REQ-022 SHALL advance a word index counter only on handshake; index resets to 0 on last-word handshake.
REQ-023 SHALL assert word_last_o only during the final word of a record.
REQ-024 SHALL pop the FIFO on last-word handshake and, if another entry exists, present its first word in the next cycle with no bubble.
REQ-025 SHALL increment records_sent_o on each last-word handshake, wrapping 0xFFFFFFFF->0.

Reset
REQ-026 SHALL on rst_n low immediately: empty FIFO, state IDLE, word index 0, records_sent_o=0, word_valid_o=0, word_last_o=0, word_data_o=0, trace_ready_o=0.
REQ-027 SHALL raise trace_ready_o first cycle after rst_n deasserts; mid-record reset discards partial record with no further words.

Configuration
REQ-028 SHALL honour macro TRACE_MEM_ACCESS_EN: defined -> 8 words/record including mem_access words; undefined -> 6 words/record, mem_access fields neither stored nor sent.

Structure
REQ-029 SHALL place trace word-count constants and word-index enum in package ryuki_datatypes alongside trace_output.
REQ-030 SHALL instantiate one sub-module trace_fifo (parameterised depth, trace_output payload, push/pop/full/empty).

Verification
REQ-031 SHALL cover single record instruction=0x00000013, addr=0x00000080, times 1..6 (8 with mem) with word_ready_i=1 -> words in REQ-019 order, last on word 8 (6), records_sent_o=1.
REQ-032 SHALL cover word_ready_i held low 3 cycles mid-record -> word_data_o stable, no word lost or repeated.
REQ-033 SHALL cover 5 back-to-back records, FIFO_DEPTH=4, word_ready_i=0 -> trace_ready_o low after 4th accepted; 5th accepted only after first record fully sent.
REQ-034 SHALL cover two queued records -> first word of record 2 immediately follows last word of record 1, no idle cycle.
REQ-035 SHALL cover rst_n asserted after word 3 -> outputs zero asynchronously, next record restarts at instruction word, records_sent_o=0.
REQ-036 SHALL cover negative integer time_start=-1 -> word 0xFFFFFFFF.
